// File: rtl/irq_source_ctrl.sv
// Interrupt-source controller feeding the CP0 hardware interrupt bus.
// Five device lines plus an internal countdown timer are latched as pending
// flags, masked, and presented on a 6-bit bus (bit 5 = timer, bits 4:0 = devices).
// Software services the block through a small word-addressed register port.
module irq_source_ctrl #(
  parameter int          TIMER_W  = 32,
  parameter logic [5:0]  MASK_RST = 6'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  dev_irq,
  input  logic [2:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [5:0]  interrupt,
  output logic        any_irq
);

  localparam logic [2:0] ADDR_PEND   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_EDGE   = 3'd2;
  localparam logic [2:0] ADDR_TLOAD  = 3'd3;
  localparam logic [2:0] ADDR_TCOUNT = 3'd4;
  localparam logic [2:0] ADDR_TCTRL  = 3'd5;

  logic [5:0]         pend;
  logic [5:0]         mask;
  logic [4:0]         edge_mode;
  logic [4:0]         dev_q;
  logic [TIMER_W-1:0] tload;
  logic [TIMER_W-1:0] tcount;
  logic               timer_en;
  logic               auto_reload;
  logic               fire_d;

  logic               wr_pend;
  logic               wr_mask;
  logic               wr_edge;
  logic               wr_tload;
  logic               wr_tctrl;
  logic [4:0]         dev_set;
  logic               count_one;
  logic               timer_fire;
  logic [5:0]         pend_clr;
  logic [5:0]         pend_set;

  // Register write strobes, request set conditions and timer expiry detection
  always_comb begin
    wr_pend    = we && (addr == ADDR_PEND);
    wr_mask    = we && (addr == ADDR_MASK);
    wr_edge    = we && (addr == ADDR_EDGE);
    wr_tload   = we && (addr == ADDR_TLOAD);
    wr_tctrl   = we && (addr == ADDR_TCTRL);
    // Edge-mode bits need a fresh rising edge; level-mode bits follow the line
    dev_set    = (edge_mode & dev_irq & ~dev_q) | (~edge_mode & dev_irq);
    count_one  = (tcount == TIMER_W'(1));
    // Any software write to the timer this cycle takes over the counter, so no fire
    timer_fire = timer_en && count_one && !wr_tload && !wr_tctrl;
    pend_clr   = wr_pend ? wd[5:0] : 6'h00;
    pend_set   = {timer_fire, dev_set};
  end

  // Pending flags (set beats write-1-to-clear), mask/edge registers, line history
  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 6'h00;
      mask      <= MASK_RST;
      edge_mode <= 5'h00;
      dev_q     <= 5'h00;
    end else begin
      pend  <= (pend & ~pend_clr) | pend_set;
      dev_q <= dev_irq;
      if (wr_mask) mask <= wd[5:0];
      if (wr_edge) edge_mode <= wd[4:0];
    end
  end

  // Countdown timer: fires on the 1->0 step, then reloads or stops one edge later
  always_ff @(posedge clk) begin
    if (rst) begin
      tload       <= '0;
      tcount      <= '0;
      timer_en    <= 1'b0;
      auto_reload <= 1'b0;
      fire_d      <= 1'b0;
    end else if (wr_tload) begin
      tload  <= wd[TIMER_W-1:0];
      tcount <= wd[TIMER_W-1:0];
      fire_d <= 1'b0;
    end else if (wr_tctrl) begin
      timer_en    <= wd[0];
      auto_reload <= wd[1];
      fire_d      <= 1'b0;
      if (wd[0] && (tcount == '0)) tcount <= tload;
    end else if (fire_d) begin
      fire_d <= 1'b0;
      if (auto_reload) tcount <= tload;
      else             timer_en <= 1'b0;
    end else if (timer_en && (tcount != '0)) begin
      tcount <= tcount - TIMER_W'(1);
      fire_d <= count_one;
    end
  end

  // Combinational read mux; unused bits and unmapped addresses read as zero
  always_comb begin
    rd = 32'h0;
    case (addr)
      ADDR_PEND:   rd = {26'h0, pend};
      ADDR_MASK:   rd = {26'h0, mask};
      ADDR_EDGE:   rd = {27'h0, edge_mode};
      ADDR_TLOAD:  rd = 32'(tload);
      ADDR_TCOUNT: rd = 32'(tcount);
      ADDR_TCTRL:  rd = {30'h0, auto_reload, timer_en};
      default:     rd = 32'h0;
    endcase
  end

  // Masked interrupt bus to CPzero and its summary bit
  always_comb begin
    interrupt = pend & mask;
    any_irq   = |interrupt;
  end

endmodule

// File: doc/irq_source_ctrl.md
Name: irq_source_ctrl

Overview:
- Interrupt-source end of the CP0 hardware interrupt interface.
- Collects five peripheral request lines plus an internal countdown timer.
- Holds the requests as pending flags, masks them, and drives the 6-bit interrupt bus into CPzero: bits 4:0 come from the devices, bit 5 from the timer.
- Software services it through a small memory-mapped word-register port: it reads pending flags, clears them write-1-to-clear, and programs mask, trigger mode and timer.

Parameters:
- TIMER_W, 32, width of the timer load/count registers (1..32); unused upper read bits return 0.
- MASK_RST, 6'h00, mask register value after reset.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- dev_irq  in  5  peripheral request lines, already synchronous to clk.
- addr  in  3  register word select (0..5 valid).
- we  in  1  write enable for addr/wd, sampled on posedge.
- wd  in  32  write data.
- rd  out  32  combinational read data for addr.
- interrupt  out  6  to CPzero interrupt input; equals pending & mask.
- any_irq  out  1  OR of interrupt bits.

Behaviour:
- Register map:
  - 0 PEND: [5:0] pending flags. Read-only except write-1-to-clear.
  - 1 MASK: [5:0] read/write.
  - 2 EDGE: [4:0] read/write; 1 = rising-edge trigger, 0 = level trigger.
  - 3 TLOAD: [TIMER_W-1:0] read/write.
  - 4 TCOUNT: read-only.
  - 5 TCTRL: bit0 EN, bit1 AUTO; read/write.
- Addresses 6,7: reads return 0, writes are ignored. Unused bits read 0.
- Reset (rst high at posedge):
  - PEND=0, MASK=MASK_RST, EDGE=0, TLOAD=0, TCOUNT=0, TCTRL=0, dev_q=0.
  - interrupt = 0 & MASK_RST = 0, any_irq=0.
  - Reset overrides any write or event in the same cycle.
- Device request capture:
  - dev_q <= dev_irq every posedge.
  - Edge mode, bit i: the set condition is dev_irq[i] & ~dev_q[i], evaluated at the posedge.
  - Level mode, bit i: the set condition is dev_irq[i].
  - Pending sets at the posedge where the set condition holds. interrupt reflects it immediately after that edge, i.e. one-cycle latency from a request line being high before the edge.
- Clearing:
  - A write to PEND clears every bit whose wd bit is 1.
  - If a set condition and a clear hit the same bit at the same edge, set wins.
  - Level bit with its line still high: it re-sets, so it stays 1.
- Masking: MASK affects only the output. Masked requests still latch in PEND, and unmasking later asserts interrupt without any new event.
- Changing EDGE: does not alter existing PEND bits.
- Timer:
  - Writing TLOAD sets TLOAD and TCOUNT to wd at the same edge.
  - While EN=1 and TCOUNT>0, TCOUNT decrements by 1 per clock.
  - At the edge where TCOUNT goes 1->0, PEND[5] sets.
  - At the next edge, if AUTO=1, TCOUNT reloads from TLOAD. If AUTO=0, EN clears and TCOUNT stays 0.
  - Writing TCTRL with EN=1 while TCOUNT=0 loads TCOUNT from TLOAD at that edge; no fire.
  - EN=1 with TLOAD=0: timer idles at 0 and never fires.
  - Writing TCTRL with EN=0 freezes TCOUNT.
  - A TLOAD write during counting restarts from the new value.
  - PEND[5] clear and timer fire at the same edge: set wins.
- Read port: rd is purely combinational from the current registers. A read and a write at the same address in one cycle return the pre-edge value.

Test Plan:
- Reset/initial: after rst, read addr 0..5 -> all 0; interrupt=6'h00. Write MASK=6'h3F, read back 32'h0000_003F; addr 6 read -> 0.
- Edge trigger:
  - Setup: EDGE=5'h01, MASK=6'h3F; pulse dev_irq[0] high for 3 cycles.
  - PEND=6'h01 one edge after the rise; no re-set after clearing it while the line is still high.
  - W1C wd=1 -> PEND=0, interrupt=0.
- Level trigger with clear collision:
  - Setup: EDGE=0; hold dev_irq[3]=1; write PEND wd=6'h08.
  - PEND[3] stays 1. Drop the line, write again -> PEND=0.
- Masking: MASK=0, raise dev_irq[1] -> PEND=6'h02, interrupt=0, any_irq=0. Then MASK=6'h02 -> interrupt=6'h02, any_irq=1 on the next cycle.
- Timer one-shot and auto-reload:
  - TLOAD=3, TCTRL=1: TCOUNT 3,2,1,0. PEND[5]=1 and interrupt[5]=1 at the third edge. Then TCTRL reads 0 and TCOUNT stays 0.
  - TCTRL=3: fires every 4 cycles; TCOUNT reloads to 3 after each fire.
- Reset mid-operation: timer at TCOUNT=2 and PEND=6'h21, assert rst one cycle -> all registers 0, no timer fire afterwards.
